// File: rtl/vu_level_meter_pkg.sv
// Shared widths and FSM state encoding for the VU level meter.
package vu_level_meter_pkg;

  localparam int unsigned LVL_W = 10;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_SCALE  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

endpackage

// File: rtl/vu_level_meter_abs_sat.sv
// Combinational magnitude of a two's-complement sample; the most negative code saturates to max positive.
module vu_level_meter_abs_sat #(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] x,
  output logic [DW-2:0] mag_c
);

  logic [DW-1:0] neg;

  always_comb begin
    neg   = DW'(~x) + DW'(1);
    mag_c = x[DW-2:0];
    if (x[DW-1]) begin
      // -2^(DW-1) negates to itself; its low bits are zero, so clamp instead
      mag_c = (neg[DW-1]) ? {(DW-1){1'b1}} : neg[DW-2:0];
    end
  end

endmodule

// File: rtl/vu_level_meter.sv
// Per-frame peak tracker: converts the frame's peak |sample| into a bar height with
// instant attack, linear release and a held peak marker, updated once per vsync edge.
module vu_level_meter
  import vu_level_meter_pkg::*;
#(
  parameter int unsigned DW          = 16,
  parameter int unsigned V_REZ       = 480,
  parameter int unsigned DECAY       = 4,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] sample,
  input  logic                 frame_sync,
  output logic [LVL_W-1:0]     level,
  output logic [LVL_W-1:0]     peak,
  output logic                 level_valid
);

  localparam int unsigned MAG_W  = DW - 1;
  localparam int unsigned PROD_W = MAG_W + LVL_W;
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned EXT_W  = LVL_W + 1;

  state_e              state_q, state_d;
  logic [MAG_W-1:0]    acc_q, acc_d;
  logic [MAG_W-1:0]    snap_q, snap_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [LVL_W-1:0]    peak_q, peak_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                level_valid_q, level_valid_d;
  logic                frame_sync_q, frame_sync_d;

  logic [MAG_W-1:0]    mag_c;
  logic                fe_c;
  logic [LVL_W-1:0]    target_c;
  logic [LVL_W-1:0]    new_level_c;

  vu_level_meter_abs_sat #(.DW(DW)) u_abs_sat (
    .x     (sample),
    .mag_c (mag_c)
  );

  assign fe_c     = frame_sync & ~frame_sync_q;
  assign target_c = LVL_W'(prod_q >> MAG_W);

  // Release rule: drop by DECAY per frame but never below the new target
  always_comb begin
    new_level_c = target_c;
    if (target_c < level_q) begin
      if (EXT_W'(level_q) > EXT_W'(target_c) + EXT_W'(DECAY)) begin
        new_level_c = level_q - LVL_W'(DECAY);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    snap_d        = snap_q;
    prod_d        = prod_q;
    level_d       = level_q;
    peak_d        = peak_q;
    hold_d        = hold_q;
    level_valid_d = 1'b0;
    frame_sync_d  = frame_sync;

    if (sample_valid && (mag_c > acc_q)) begin
      acc_d = mag_c;
    end

    case (state_q)
      ST_ACCUM: begin
        if (fe_c) begin
          // A sample coincident with the edge opens the new window, not the closing one
          snap_d  = acc_q;
          acc_d   = sample_valid ? mag_c : '0;
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        prod_d  = PROD_W'(snap_q) * PROD_W'(V_REZ);
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        level_d       = new_level_c;
        level_valid_d = 1'b1;
        state_d       = ST_ACCUM;
        if (new_level_c >= peak_q) begin
          peak_d = new_level_c;
          hold_d = HOLD_W'(HOLD_FRAMES);
        end else if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else if (EXT_W'(peak_q) > EXT_W'(new_level_c) + EXT_W'(DECAY)) begin
          peak_d = peak_q - LVL_W'(DECAY);
        end else begin
          peak_d = new_level_c;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ACCUM;
      acc_q         <= '0;
      snap_q        <= '0;
      prod_q        <= '0;
      level_q       <= '0;
      peak_q        <= '0;
      hold_q        <= '0;
      level_valid_q <= 1'b0;
      frame_sync_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      snap_q        <= snap_d;
      prod_q        <= prod_d;
      level_q       <= level_d;
      peak_q        <= peak_d;
      hold_q        <= hold_d;
      level_valid_q <= level_valid_d;
      frame_sync_q  <= frame_sync_d;
    end
  end

  assign level       = level_q;
  assign peak        = peak_q;
  assign level_valid = level_valid_q;

endmodule

// File: tb/tb_vu_level_meter.sv
// Directed bench for vu_level_meter: hand-computed level/peak per frame.
module tb_vu_level_meter;

  logic               clk;
  logic               rst;
  logic               sample_valid;
  logic signed [15:0] sample;
  logic               frame_sync;
  logic [9:0]         level;
  logic [9:0]         peak;
  logic               level_valid;

  int checks = 0;
  int passes = 0;

  vu_level_meter dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .frame_sync   (frame_sync),
    .level        (level),
    .peak         (peak),
    .level_valid  (level_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send_sample(input logic [15:0] s);
    sample_valid = 1'b1;
    sample       = s;
    tick();
    sample_valid = 1'b0;
  endtask

  // Raise vsync (optionally with a coincident sample) and check the 3-edge update
  task automatic frame(input string tag, input int exp_lvl, input int exp_pk,
                       input logic sv, input logic [15:0] s);
    frame_sync   = 1'b1;
    sample_valid = sv;
    sample       = s;
    tick();
    sample_valid = 1'b0;
    tick();
    check({tag, "_lv_early"}, 32'(level_valid), 32'd0);
    tick();
    check({tag, "_lv"}, 32'(level_valid), 32'd1);
    check({tag, "_level"}, 32'(level), 32'(exp_lvl));
    check({tag, "_peak"}, 32'(peak), 32'(exp_pk));
    frame_sync = 1'b0;
    tick();
    check({tag, "_lv_pulse"}, 32'(level_valid), 32'd0);
  endtask

  initial begin
    int el;
    int ep;
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;
    frame_sync   = 1'b0;
    repeat (5) tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_peak", 32'(peak), 32'd0);
    check("rst_lv", 32'(level_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Silence after reset
    for (int i = 0; i < 3; i++) frame("idle", 0, 0, 1'b0, 16'h0000);

    // Full-scale positive
    send_sample(16'h7FFF);
    frame("full_pos", 479, 479, 1'b0, 16'h0000);

    // Release and peak hold: 30 held frames then 4/frame decay
    for (int k = 1; k <= 32; k++) begin
      el = 479 - 4 * k;
      ep = (k <= 30) ? 479 : 479 - 4 * (k - 30);
      frame("release", el, ep, 1'b0, 16'h0000);
    end

    // Most negative code saturates, instant attack
    send_sample(16'h8000);
    frame("neg_sat", 479, 479, 1'b0, 16'h0000);

    // Reset during UPDATE wins
    frame_sync = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_upd_lv", 32'(level_valid), 32'd0);
    check("rst_upd_level", 32'(level), 32'd0);
    check("rst_upd_peak", 32'(peak), 32'd0);
    rst        = 1'b0;
    frame_sync = 1'b0;
    tick();
    check("rst_upd_lv_after", 32'(level_valid), 32'd0);
    check("rst_upd_level_after", 32'(level), 32'd0);

    // Sample coincident with edge goes to the next window (4096 -> 60, 16384 -> 240)
    send_sample(16'h1000);
    frame("coincident", 60, 60, 1'b1, 16'h4000);
    frame("next_window", 240, 240, 1'b0, 16'h0000);

    // Negative magnitude (-24576 -> 360) attacks above previous level
    send_sample(16'hA000);
    frame("neg_mag", 360, 360, 1'b0, 16'h0000);

    // Window holds max of several samples: max |x| = 8192 -> target 120, level releases 360 -> 356
    send_sample(16'h1000);
    send_sample(16'hE000);
    send_sample(16'h0800);
    frame("multi_release", 356, 360, 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
